rst_seq_mgr: RTL and testbench

- Parametrised reset manager that replaces the single-output power-on reset stretcher at the top level of the SoC.
- Holds all reset domains asserted for a programmable time, then releases N_OUT domains in a staggered sequence.
- Re-enters reset on any of three triggers: a debounced board button, a software request, or watchdog expiry.
- Records the cause of the last reset for firmware.

---
 rtl/rst_seq_mgr_if.sv | 22 ++
 rtl/rst_seq_mgr.sv | 179 +++++++++++++++++
 tb/tb_rst_seq_mgr.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/rst_seq_mgr_if.sv
// rtl/rst_seq_mgr_if.sv - reset manager trigger inputs and per-domain reset outputs
interface rst_seq_mgr_if #(
  parameter int N_OUT = 2
);
  logic             btn_i;
  logic             soft_rst_i;
  logic             wdog_en_i;
  logic             wdog_kick_i;
  logic [N_OUT-1:0] rst_o;
  logic             rst_done_o;
  logic [1:0]       rst_cause_o;

  modport master (
    output btn_i, soft_rst_i, wdog_en_i, wdog_kick_i,
    input  rst_o, rst_done_o, rst_cause_o
  );

  modport slave (
    input  btn_i, soft_rst_i, wdog_en_i, wdog_kick_i,
    output rst_o, rst_done_o, rst_cause_o
  );
endinterface

// File: rtl/rst_seq_mgr.sv
// rtl/rst_seq_mgr.sv - staggered multi-domain reset sequencer with button, soft and watchdog triggers
module rst_seq_mgr #(
  parameter int N_OUT       = 2,
  parameter int HOLD_CYC    = 65535,
  parameter int STAGGER_CYC = 16,
  parameter int DEB_CYC     = 100000,
  parameter int WDOG_CYC    = 2**24
) (
  input  logic          clk,
  input  logic          rst,
  rst_seq_mgr_if.slave  bus
);

  localparam int HW = (HOLD_CYC    > 1) ? $clog2(HOLD_CYC)    : 1;
  localparam int SW = (STAGGER_CYC > 1) ? $clog2(STAGGER_CYC) : 1;
  localparam int DW = (DEB_CYC     > 1) ? $clog2(DEB_CYC)     : 1;
  localparam int WW = (WDOG_CYC    > 1) ? $clog2(WDOG_CYC)    : 1;
  localparam int IW = (N_OUT       > 1) ? $clog2(N_OUT)       : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER_CYC - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_OUT - 1);

  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_BTN  = 2'd1;
  localparam logic [1:0] CAUSE_SOFT = 2'd2;
  localparam logic [1:0] CAUSE_WDOG = 2'd3;

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_STAGGER = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [SW-1:0]    stag_q, stag_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [N_OUT-1:0] rst_q, rst_d;
  logic             done_q, done_d;
  logic [1:0]       cause_q, cause_d;

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [DW-1:0]    deb_q, deb_d;
  logic [WW-1:0]    wdog_q, wdog_d;

  logic             btn_trig, wdog_trig, trig;
  logic [1:0]       cause_sel;

  // Debounce the synchronised button, run the watchdog and merge the trigger sources
  always_comb begin
    stable_d  = stable_q;
    deb_d     = '0;
    btn_trig  = 1'b0;
    wdog_d    = '0;
    wdog_trig = 1'b0;
    if (sync2_q != stable_q) begin
      if (deb_q == DEB_LAST) begin
        stable_d = sync2_q;
        btn_trig = sync2_q;   // only the press edge resets; release just updates the flag
      end else begin
        deb_d = deb_q + DW'(1);
      end
    end
    if ((state_q == S_RUN) && bus.wdog_en_i) begin
      if (bus.wdog_kick_i) begin
        wdog_d = '0;          // a kick wins over an expiry in the same cycle
      end else if (wdog_q == WDOG_LAST) begin
        wdog_trig = 1'b1;
      end else begin
        wdog_d = wdog_q + WW'(1);
      end
    end
    trig = btn_trig | bus.soft_rst_i | wdog_trig;
    if (wdog_trig) begin
      cause_sel = CAUSE_WDOG;
    end else if (bus.soft_rst_i) begin
      cause_sel = CAUSE_SOFT;
    end else begin
      cause_sel = CAUSE_BTN;
    end
  end

  // Sequencer: hold all domains, release them one by one, then watch for triggers
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    stag_d  = stag_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    done_d  = done_q;
    cause_d = cause_q;
    if (trig) begin
      state_d = S_HOLD;
      hold_d  = '0;
      stag_d  = '0;
      idx_d   = '0;
      rst_d   = '1;
      done_d  = 1'b0;
      cause_d = cause_sel;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            rst_d[0] = 1'b0;
            if (N_OUT == 1) begin
              state_d = S_RUN;
              done_d  = 1'b1;
            end else begin
              state_d = S_STAGGER;
              idx_d   = IW'(1);
              stag_d  = '0;
            end
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        S_STAGGER: begin
          if (stag_q == STAG_LAST) begin
            rst_d[idx_q] = 1'b0;
            stag_d       = '0;
            if (idx_q == IDX_LAST) begin
              state_d = S_RUN;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            stag_d = stag_q + SW'(1);
          end
        end
        S_RUN: begin
        end
        default: begin
          state_d = S_HOLD;
        end
      endcase
    end
  end

  // State and counter registers; board reset forces the full POR sequence
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_HOLD;
      hold_q   <= '0;
      stag_q   <= '0;
      idx_q    <= '0;
      rst_q    <= '1;
      done_q   <= 1'b0;
      cause_q  <= CAUSE_POR;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      deb_q    <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      stag_q   <= stag_d;
      idx_q    <= idx_d;
      rst_q    <= rst_d;
      done_q   <= done_d;
      cause_q  <= cause_d;
      sync1_q  <= bus.btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      deb_q    <= deb_d;
      wdog_q   <= wdog_d;
    end
  end

  assign bus.rst_o       = rst_q;
  assign bus.rst_done_o  = done_q;
  assign bus.rst_cause_o = cause_q;

endmodule

// File: tb/tb_rst_seq_mgr.sv
// tb/tb_rst_seq_mgr.sv - vector table, corner sequences and randomized model check for rst_seq_mgr
module tb_rst_seq_mgr;
  localparam int N = 3, HOLD = 8, STAG = 4, DEB = 5, WD = 20;
  localparam int SEQ_LEN = HOLD + (N - 1) * STAG;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rst_seq_mgr_if #(.N_OUT(N)) bus ();

  rst_seq_mgr #(
    .N_OUT(N), .HOLD_CYC(HOLD), .STAGGER_CYC(STAG), .DEB_CYC(DEB), .WDOG_CYC(WD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    logic       r, b, s, e, k;
    int         ncyc;
    logic [2:0] x_rst;
    logic       x_done;
    logic [1:0] x_cause;
  } vec_t;

  vec_t tbl[$];

  // reference model: elapsed time since sequence start plus button/watchdog histories
  bit         rawq[$];
  bit         synq[$];
  bit         m_stable;
  int         m_el;
  int         m_wd;
  logic [2:0] m_rst;
  bit         m_done;
  logic [1:0] m_cause;

  function automatic void add(string nm, logic r, logic b, logic s, logic e, logic k,
                              int n, logic [2:0] xr, logic xd, logic [1:0] xc);
    vec_t v;
    v.name = nm; v.r = r; v.b = b; v.s = s; v.e = e; v.k = k;
    v.ncyc = n; v.x_rst = xr; v.x_done = xd; v.x_cause = xc;
    tbl.push_back(v);
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit syn, btrig, wtrig, strig;
    if (rst) begin
      rawq.delete(); rawq.push_back(1'b0); rawq.push_back(1'b0);
      synq.delete();
      m_stable = 1'b0; m_el = 0; m_wd = 0;
      m_rst = '1; m_done = 1'b0; m_cause = 2'd0;
      return;
    end
    syn = rawq[rawq.size() - 2];
    rawq.push_back(bus.btn_i);
    if (rawq.size() > 4) void'(rawq.pop_front());
    btrig = 1'b0;
    if (syn == m_stable) begin
      synq.delete();
    end else begin
      synq.push_back(syn);
      if (synq.size() == DEB) begin
        m_stable = syn;
        btrig    = syn;
        synq.delete();
      end
    end
    wtrig = 1'b0;
    if (m_done && bus.wdog_en_i && !bus.wdog_kick_i) begin
      m_wd++;
      if (m_wd == WD) wtrig = 1'b1;
    end else begin
      m_wd = 0;
    end
    strig = bus.soft_rst_i;
    if (btrig || strig || wtrig) begin
      m_cause = wtrig ? 2'd3 : (strig ? 2'd2 : 2'd1);
      m_el = 0; m_wd = 0; m_rst = '1; m_done = 1'b0;
    end else begin
      if (m_el < 1000000) m_el++;
      for (int k = 0; k < N; k++) m_rst[k] = (m_el < HOLD + k * STAG);
      m_done = (m_el >= SEQ_LEN);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(logic r, logic b, logic s, logic e, logic k);
    rst = r; bus.btn_i = b; bus.soft_rst_i = s; bus.wdog_en_i = e; bus.wdog_kick_i = k;
  endtask

  initial begin
    int cnt;
    bit seen;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    //   name            r  b  s  e  k  cyc  rst_o   done cause
    add("por_hold",      1, 0, 0, 0, 0, 2,  3'b111, 0, 2'd0);
    add("por_e7",        0, 0, 0, 0, 0, 7,  3'b111, 0, 2'd0);
    add("por_e8",        0, 0, 0, 0, 0, 1,  3'b110, 0, 2'd0);
    add("por_e11",       0, 0, 0, 0, 0, 3,  3'b110, 0, 2'd0);
    add("por_e12",       0, 0, 0, 0, 0, 1,  3'b100, 0, 2'd0);
    add("por_e15",       0, 0, 0, 0, 0, 3,  3'b100, 0, 2'd0);
    add("por_e16",       0, 0, 0, 0, 0, 1,  3'b000, 1, 2'd0);
    add("soft_assert",   0, 0, 1, 0, 0, 1,  3'b111, 0, 2'd2);
    add("soft_e8",       0, 0, 0, 0, 0, 8,  3'b110, 0, 2'd2);
    add("soft_e16",      0, 0, 0, 0, 0, 8,  3'b000, 1, 2'd2);
    add("mid_soft",      0, 0, 1, 0, 0, 1,  3'b111, 0, 2'd2);
    add("mid_e9",        0, 0, 0, 0, 0, 9,  3'b110, 0, 2'd2);
    add("mid_restart",   0, 0, 1, 0, 0, 1,  3'b111, 0, 2'd2);
    add("mid_e7",        0, 0, 0, 0, 0, 7,  3'b111, 0, 2'd2);
    add("mid_e8",        0, 0, 0, 0, 0, 1,  3'b110, 0, 2'd2);
    add("mid_e16",       0, 0, 0, 0, 0, 8,  3'b000, 1, 2'd2);
    add("wd_kick0",      0, 0, 0, 1, 1, 1,  3'b000, 1, 2'd2);
    add("wd_gap1",       0, 0, 0, 1, 0, 9,  3'b000, 1, 2'd2);
    add("wd_kick1",      0, 0, 0, 1, 1, 1,  3'b000, 1, 2'd2);
    add("wd_gap2",       0, 0, 0, 1, 0, 9,  3'b000, 1, 2'd2);
    add("wd_kick2",      0, 0, 0, 1, 1, 1,  3'b000, 1, 2'd2);
    add("wd_e19",        0, 0, 0, 1, 0, 19, 3'b000, 1, 2'd2);
    add("wd_fire",       0, 0, 0, 1, 0, 1,  3'b111, 0, 2'd3);
    add("wd_recover",    0, 0, 0, 0, 0, 16, 3'b000, 1, 2'd3);
    add("wdk_kick",      0, 0, 0, 1, 1, 1,  3'b000, 1, 2'd3);
    add("wdk_e19",       0, 0, 0, 1, 0, 19, 3'b000, 1, 2'd3);
    add("wdk_same",      0, 0, 0, 1, 1, 1,  3'b000, 1, 2'd3);
    add("wdk_more",      0, 0, 0, 1, 0, 5,  3'b000, 1, 2'd3);
    add("sim_pre",       0, 0, 0, 1, 0, 14, 3'b000, 1, 2'd3);
    add("sim_soft_wd",   0, 0, 1, 1, 0, 1,  3'b111, 0, 2'd3);
    add("stag_run",      0, 0, 0, 0, 0, 12, 3'b100, 0, 2'd3);
    add("rst_in_stag",   1, 0, 0, 0, 0, 1,  3'b111, 0, 2'd0);
    add("rst_rel",       0, 0, 0, 0, 0, 16, 3'b000, 1, 2'd0);
    add("btn_glitch",    0, 1, 0, 0, 0, 3,  3'b000, 1, 2'd0);
    add("btn_quiet",     0, 0, 0, 0, 0, 10, 3'b000, 1, 2'd0);
    add("btn_hold6",     0, 1, 0, 0, 0, 6,  3'b000, 1, 2'd0);
    add("btn_accept",    0, 1, 0, 0, 0, 1,  3'b111, 0, 2'd1);
    add("btn_hold_rest", 0, 1, 0, 0, 0, 3,  3'b111, 0, 2'd1);
    add("btn_release",   0, 0, 0, 0, 0, 13, 3'b000, 1, 2'd1);
    add("btn_rel_quiet", 0, 0, 0, 0, 0, 10, 3'b000, 1, 2'd1);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].b, tbl[i].s, tbl[i].e, tbl[i].k);
      for (int c = 0; c < tbl[i].ncyc; c++) step();
      check({tbl[i].name, ".rst_o"},       32'(bus.rst_o),       32'(tbl[i].x_rst));
      check({tbl[i].name, ".rst_done_o"},  32'(bus.rst_done_o),  32'(tbl[i].x_done));
      check({tbl[i].name, ".rst_cause_o"}, 32'(bus.rst_cause_o), 32'(tbl[i].x_cause));
    end

    // edge-exact release timing after board reset
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int e = 1; e <= SEQ_LEN + 2; e++) begin
      logic [2:0] xr;
      step();
      for (int k = 0; k < N; k++) xr[k] = (e < HOLD + k * STAG);
      check($sformatf("por_edge%0d.rst_o", e), 32'(bus.rst_o), 32'(xr));
      check($sformatf("por_edge%0d.done", e), 32'(bus.rst_done_o), 32'(e >= SEQ_LEN));
    end

    // bounded wait for completion after a soft pulse
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cnt = 0;
    seen = 1'b0;
    while (!seen && cnt < 200) begin
      step();
      cnt++;
      if (bus.rst_done_o === 1'b1) seen = 1'b1;
    end
    check("soft_done_latency", 32'(cnt), 32'(SEQ_LEN));
    check("soft_done_cause", 32'(bus.rst_cause_o), 32'd2);

    // randomized traffic against the reference model
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) bus.btn_i = ~bus.btn_i;
      bus.soft_rst_i  = ($urandom_range(0, 59) == 0);
      bus.wdog_kick_i = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 199) == 0) bus.wdog_en_i = ~bus.wdog_en_i;
      rst = ($urandom_range(0, 499) == 0);
      step();
      check("rnd.rst_o",       32'(bus.rst_o),       32'(m_rst));
      check("rnd.rst_done_o",  32'(bus.rst_done_o),  32'(m_done));
      check("rnd.rst_cause_o", 32'(bus.rst_cause_o), 32'(m_cause));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
